// File: rtl/ioports_host_sequencer_pkg.sv
// Shared encodings for the I/O port host sequencer: requester ops,
// port-block command codes, FSM states and the auto-zero port address.
package ioports_host_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_RSTP  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  localparam logic [2:0] CMD_RESET = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b010;
  localparam logic [2:0] CMD_READ  = 3'b011;

  // Port 15 returns to zero on its own and the port block ignores load
  // while that is pending.
  localparam logic [3:0] ADDR_AUTOZERO = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_GAP   = 3'd2,
    S_WBYTE = 3'd3,
    S_RREQ  = 3'd4,
    S_RREL  = 3'd5,
    S_HOLD  = 3'd6,
    S_FIN   = 3'd7
  } state_e;

  // Command nibble carried in bits [6:4] of the command byte.
  function automatic logic [2:0] op2cmd(input logic [1:0] op);
    logic [2:0] c;
    case (op)
      OP_WRITE: c = CMD_WRITE;
      OP_READ:  c = CMD_READ;
      OP_RSTP:  c = CMD_RESET;
      default:  c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ioports_rr_arb2.sv
// Two-way round-robin arbiter. A lone request wins outright; when both
// request, the one not granted last wins. Pointer moves only on accept.
module ioports_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  // r_last = index of the requester granted most recently
  logic r_last;

  // grant selection
  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) o_gnt = r_last ? 2'b01 : 2'b10;
    else                o_gnt = i_req;
  end

  // pointer update; reset value makes requester 0 win first
  always_ff @(posedge clk) begin
    if (!reset)                    r_last <= 1'b1;
    else if (i_accept && |o_gnt)   r_last <= o_gnt[1];
  end

endmodule

// File: rtl/ioports_host_sequencer.sv
// Arbitrates two requesters onto the byte-serial command bus of the I/O
// port block and sequences write / read / reset-ports transactions.
module ioports_host_sequencer
  import ioports_host_sequencer_pkg::*;
#(
  parameter int LOAD_GAP = 1,
  parameter int F_HOLD   = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [1:0]  req0_op,
  input  logic [3:0]  req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  input  logic [1:0]  req1_op,
  input  logic [3:0]  req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        done0,
  output logic        done1,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        io_load,
  output logic [7:0]  io_datain,
  output logic        io_ready,
  input  logic        io_enout,
  input  logic [7:0]  io_dataout
);

  // Terminal counts for the shared cycle counter (it restarts at 0 on
  // every state change).
  localparam logic [7:0] GAP_LAST  = (LOAD_GAP > 0) ? 8'(LOAD_GAP - 1) : 8'd0;
  localparam logic [7:0] HOLD_LAST = 8'(F_HOLD);
  localparam logic [7:0] TMO_LAST  = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_op;
  logic [3:0]  r_addr;
  logic [31:0] r_wdata;
  logic        r_owner;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_cnt;
  logic [1:0]  r_bcnt;

  logic [1:0]  w_gnt;
  logic [1:0]  w_gop;
  logic        w_accept;
  logic        w_capture;
  logic        w_tmo;
  logic        w_bstep;
  logic        w_last_byte;
  logic [7:0]  w_wbyte;
  state_e      w_gap_tgt;
  state_e      w_post_load;

  ioports_rr_arb2 u_arb (
    .clk      (clk),
    .reset    (reset),
    .i_req    ({req1_valid, req0_valid}),
    .i_accept (w_accept),
    .o_gnt    (w_gnt)
  );

  assign w_gop       = w_gnt[1] ? req1_op : req0_op;
  assign w_last_byte = (r_bcnt == 2'd3);
  // After a load pulse either sit out the gap or go straight on.
  assign w_gap_tgt   = (r_op == OP_READ) ? S_RREQ : S_WBYTE;
  assign w_post_load = (LOAD_GAP > 0) ? S_GAP : w_gap_tgt;

  // write data byte for the current byte slot, MS byte first
  always_comb begin
    case (r_bcnt)
      2'd0:    w_wbyte = r_wdata[31:24];
      2'd1:    w_wbyte = r_wdata[23:16];
      2'd2:    w_wbyte = r_wdata[15:8];
      default: w_wbyte = r_wdata[7:0];
    endcase
  end

  // next state, bus outputs and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    io_load     = 1'b0;
    io_datain   = 8'h00;
    io_ready    = 1'b0;
    done0       = 1'b0;
    done1       = 1'b0;
    rsp_err     = 1'b0;
    rsp_rdata   = 32'h0;
    busy        = (r_state != S_IDLE);
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_tmo       = 1'b0;
    w_bstep     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_gnt) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_gop == OP_RSVD) ? S_FIN : S_CMD;
        end
      end
      S_CMD: begin
        io_load     = 1'b1;
        io_datain   = {1'b0, op2cmd(r_op), r_addr};
        w_state_nxt = (r_op == OP_RSTP) ? S_FIN : w_post_load;
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) w_state_nxt = w_gap_tgt;
      end
      S_WBYTE: begin
        io_load   = 1'b1;
        io_datain = w_wbyte;
        w_bstep   = 1'b1;
        if (w_last_byte)
          w_state_nxt = (r_addr == ADDR_AUTOZERO) ? S_HOLD : S_FIN;
        else
          w_state_nxt = w_post_load;
      end
      S_RREQ: begin
        io_ready = 1'b1;
        if (io_enout) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RREL;
        end else if (r_cnt == TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_RREL: begin
        if (!io_enout) begin
          w_bstep     = 1'b1;
          w_state_nxt = w_last_byte ? S_FIN : S_RREQ;
        end else if (r_cnt == TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_FIN;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        done0       = ~r_owner;
        done1       = r_owner;
        rsp_err     = r_err;
        rsp_rdata   = (r_op == OP_READ && !r_err) ? r_rdata : 32'h0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state, counters and latched transaction fields
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_addr  <= 4'h0;
      r_wdata <= 32'h0;
      r_owner <= 1'b0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
      r_cnt   <= 8'h00;
      r_bcnt  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state || r_state == S_IDLE) r_cnt <= 8'h00;
      else                                              r_cnt <= r_cnt + 8'd1;
      if (w_accept) begin
        r_owner <= w_gnt[1];
        r_op    <= w_gop;
        r_addr  <= w_gnt[1] ? req1_addr  : req0_addr;
        r_wdata <= w_gnt[1] ? req1_wdata : req0_wdata;
        r_rdata <= 32'h0;
        r_err   <= (w_gop == OP_RSVD);
        r_bcnt  <= 2'd0;
      end
      if (w_capture) r_rdata <= {r_rdata[23:0], io_dataout};
      if (w_tmo) begin
        r_err   <= 1'b1;
        r_rdata <= 32'h0;
      end
      if (w_bstep) r_bcnt <= r_bcnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_ioports_host_sequencer.sv
// Bench for ioports_host_sequencer: a port-block responder, requester
// drivers, and a transaction-level model that expands each granted
// transaction into the cycle-by-cycle bus/response trace it must produce.
module tb_ioports_host_sequencer;

  localparam int LG = 1;
  localparam int FH = 2;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_op, req1_op;
  logic [3:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        done0, done1, rsp_err, busy, io_load, io_ready, io_enout;
  logic [31:0] rsp_rdata;
  logic [7:0]  io_datain, io_dataout;

  ioports_host_sequencer #(.LOAD_GAP(LG), .F_HOLD(FH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .done0(done0), .done1(done1), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .io_load(io_load), .io_datain(io_datain), .io_ready(io_ready),
    .io_enout(io_enout), .io_dataout(io_dataout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- port-block responder ----------------
  logic [31:0] pin [16];
  logic [31:0] pout[16];
  logic        enout_dead;
  int          ph, rd_idx, wr15_cnt, hold_viol;
  logic [3:0]  waddr, rd_addr;
  logic [31:0] wacc, last_wr15;
  logic        rd_on;
  int          af_cnt;

  always @(posedge clk) begin
    if (!rst) begin
      ph <= 0; rd_on <= 1'b0; rd_idx <= 0; af_cnt <= 0;
      io_enout <= 1'b0; io_dataout <= 8'h00;
      for (int i = 0; i < 16; i++) pout[i] <= 32'h0;
    end else begin
      if (af_cnt != 0) begin
        af_cnt <= af_cnt - 1;
        if (af_cnt == 1) pout[15] <= 32'h0;
      end
      if (io_load) begin
        if (af_cnt != 0) hold_viol <= hold_viol + 1;
        if (ph == 0) begin
          rd_on <= 1'b0;
          case (io_datain[6:4])
            3'b010: begin ph <= 1; waddr <= io_datain[3:0]; end
            3'b011: begin rd_on <= 1'b1; rd_idx <= 0; rd_addr <= io_datain[3:0]; end
            3'b001: for (int i = 0; i < 16; i++) pout[i] <= 32'h0;
            default: ;
          endcase
        end else begin
          wacc <= {wacc[23:0], io_datain};
          if (ph == 4) begin
            ph <= 0;
            pout[waddr] <= {wacc[23:0], io_datain};
            if (waddr == 4'hF) begin
              last_wr15 <= {wacc[23:0], io_datain};
              wr15_cnt  <= wr15_cnt + 1;
              af_cnt    <= FH + 1;
            end
          end else ph <= ph + 1;
        end
      end
      if (rd_on && io_ready && !io_enout && !enout_dead && rd_idx < 4) begin
        io_enout   <= 1'b1;
        io_dataout <= 8'(pin[rd_addr] >> (8 * (3 - rd_idx)));
        rd_idx     <= rd_idx + 1;
      end else if (!io_ready) io_enout <= 1'b0;
    end
  end

  // ---------------- requester drivers ----------------
  typedef struct packed { logic [1:0] op; logic [3:0] addr; logic [31:0] wd; } txn_t;
  txn_t q0[$], q1[$];
  int   rise0, rise1;

  initial begin
    txn_t t;
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req0_addr = 0; req0_wdata = 0;
    req1_op = 0; req1_addr = 0; req1_wdata = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        req0_valid = 0; req1_valid = 0; q0.delete(); q1.delete();
      end else begin
        if (req0_valid && done0) req0_valid = 0;
        if (req1_valid && done1) req1_valid = 0;
        if (!req0_valid && q0.size() != 0) begin
          t = q0.pop_front();
          req0_op = t.op; req0_addr = t.addr; req0_wdata = t.wd; req0_valid = 1; rise0 = cyc;
        end
        if (!req1_valid && q1.size() != 0) begin
          t = q1.pop_front();
          req1_op = t.op; req1_addr = t.addr; req1_wdata = t.wd; req1_valid = 1; rise1 = cyc;
        end
      end
    end
  end

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic busy; logic load; logic [7:0] datain; logic ready;
    logic d0; logic d1; logic err; logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  logic m_last;

  task automatic push(input logic ld, input logic [7:0] d, input logic rdy,
                      input logic f0, input logic f1, input logic er, input logic [31:0] rd);
    exp_t e;
    e.busy = 1'b1; e.load = ld; e.datain = d; e.ready = rdy;
    e.d0 = f0; e.d1 = f1; e.err = er; e.rdata = rd;
    exp_q.push_back(e);
  endtask
  task automatic p_idle();  push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); endtask
  task automatic p_ready(); push(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); endtask
  task automatic p_load(input logic [7:0] d); push(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0); endtask
  task automatic p_fin(input logic who, input logic er, input logic [31:0] rd);
    push(1'b0, 8'h00, 1'b0, !who, who, er, rd);
  endtask

  // Expand one granted transaction into the cycles that follow the grant.
  task automatic build(input logic who, input logic [1:0] op, input logic [3:0] a,
                       input logic [31:0] wd);
    logic [31:0] v;
    case (op)
      2'b00: begin
        p_load({4'b0010, a});
        for (int b = 0; b < 4; b++) begin
          repeat (LG) p_idle();
          v = wd << (8 * b);
          p_load(v[31:24]);
        end
        if (a == 4'hF) repeat (FH + 1) p_idle();
        p_fin(who, 1'b0, 32'h0);
      end
      2'b01: begin
        p_load({4'b0011, a});
        repeat (LG) p_idle();
        if (enout_dead) begin
          repeat (TO) p_ready();
          p_fin(who, 1'b1, 32'h0);
        end else begin
          // responder raises enout one cycle after ready, drops it one after
          repeat (4) begin p_ready(); p_ready(); p_idle(); p_idle(); end
          p_fin(who, 1'b0, pin[a]);
        end
      end
      2'b10: begin
        p_load({4'b0001, a});
        p_fin(who, 1'b0, 32'h0);
      end
      default: p_fin(who, 1'b1, 32'h0);
    endcase
  endtask

  initial begin
    logic who;
    m_last = 1'b1;
    forever begin
      @(posedge clk);
      if (!rst) begin
        exp_q.delete(); m_last = 1'b1;
      end else if (exp_q.size() != 0) begin
        exp_q.delete(0);
      end else if (req0_valid || req1_valid) begin
        who = (req0_valid && req1_valid) ? !m_last : req1_valid;
        m_last = who;
        if (who) build(1'b1, req1_op, req1_addr, req1_wdata);
        else     build(1'b0, req0_op, req0_addr, req0_wdata);
      end
    end
  end

  // ---------------- per-cycle compare + done monitor ----------------
  int          ndone = 0, nload = 0, done_cyc = 0;
  logic [5:0]  log_w = 6'h0;
  logic        last_err;
  logic [31:0] last_rdata;

  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (exp_q.size() != 0) e = exp_q[0];
        else                   e = '0;
        a = {busy, io_load, io_datain, io_ready, done0, done1, rsp_err, rsp_rdata};
        chk("cycle_outputs", 64'(a), 64'(e));
        if (done0 || done1) begin
          ndone++;
          log_w = {log_w[4:0], done1};
          last_err = rsp_err; last_rdata = rsp_rdata; done_cyc = cyc;
        end
        if (io_load) nload++;
      end
    end
  end

  task automatic wait_done(input int n);
    for (int k = 0; k < 500 && ndone < n; k++) @(posedge clk);
    chk("done_count", 64'(ndone), 64'(n));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base, nl;
    enout_dead = 1'b0;
    hold_viol = 0; wr15_cnt = 0; last_wr15 = 32'h0; wacc = 32'h0;
    waddr = 4'h0; rd_addr = 4'h0;
    for (int i = 0; i < 16; i++) pin[i] = 32'h0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_load", 64'({io_load, io_ready, done0, done1}), 64'd0);
    rst = 1'b1;
    @(posedge clk);

    // write port 3
    q0.push_back('{2'b00, 4'h3, 32'h12345678});
    wait_done(1);
    chk("wr3_out", 64'(pout[3]), 64'h12345678);
    chk("wr3_latency", 64'(done_cyc - rise0), 64'd10);
    chk("wr3_err", 64'(last_err), 64'd0);

    // read port 2 via requester 1
    pin[2] = 32'hCAFEF00D;
    q1.push_back('{2'b01, 4'h2, 32'h0});
    wait_done(2);
    chk("rd2_data", 64'(last_rdata), 64'hCAFEF00D);
    chk("rd2_err", 64'(last_err), 64'd0);

    // both requesters writing, three times each
    log_w = 6'h0;
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{2'b00, 4'(4 + i), 32'h01010101 * (i + 1)});
      q1.push_back('{2'b00, 4'(8 + i), 32'h10203040 + i});
    end
    wait_done(8);
    chk("arb_order", 64'(log_w), 64'b010101);
    chk("arb_wr5", 64'(pout[5]), 64'h02020202);
    chk("arb_wr10", 64'(pout[10]), 64'h10203042);

    // back-to-back writes to the auto-zero port
    q0.push_back('{2'b00, 4'hF, 32'h00000001});
    q1.push_back('{2'b00, 4'hF, 32'h5A5A0001});
    wait_done(10);
    repeat (6) @(posedge clk);
    chk("f_writes", 64'(wr15_cnt), 64'd2);
    chk("f_last", 64'(last_wr15), 64'h5A5A0001);
    chk("f_autozero", 64'(pout[15]), 64'h0);
    chk("f_hold_window", 64'(hold_viol), 64'd0);

    // read timeout with enout stuck low
    enout_dead = 1'b1;
    q0.push_back('{2'b01, 4'h5, 32'h0});
    wait_done(11);
    chk("tmo_err", 64'(last_err), 64'd1);
    chk("tmo_rdata", 64'(last_rdata), 64'h0);
    chk("tmo_latency", 64'(done_cyc - rise0), 64'(3 + TO));
    enout_dead = 1'b0;
    q1.push_back('{2'b00, 4'h7, 32'hCAFE0007});
    wait_done(12);
    chk("post_tmo_wr", 64'(pout[7]), 64'hCAFE0007);

    // reset-ports clears every output port
    q0.push_back('{2'b10, 4'h0, 32'h0});
    wait_done(13);
    chk("rstp_out7", 64'(pout[7]), 64'h0);
    chk("rstp_err", 64'(last_err), 64'd0);

    // reset in the middle of a read, after two bytes were captured
    pin[1] = 32'h11223344;
    pin[0] = 32'hA5A5A5A5;
    q0.push_back('{2'b01, 4'h1, 32'h0});
    @(posedge clk); #2;
    for (int k = 0; k < 60 && cyc != rise0 + 9; k++) @(negedge clk);
    chk("mid_rst_reached", 64'(cyc), 64'(rise0 + 9));
    base = ndone;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_idle", 64'({busy, io_ready, io_load}), 64'd0);
    repeat (5) @(posedge clk);
    chk("mid_rst_nodone", 64'(ndone), 64'(base));
    q0.push_back('{2'b01, 4'h0, 32'h0});
    wait_done(base + 1);
    chk("post_rst_rdata", 64'(last_rdata), 64'hA5A5A5A5);

    // reserved op: immediate error, no bus activity
    nl = nload;
    q1.push_back('{2'b11, 4'h3, 32'hFFFFFFFF});
    wait_done(base + 2);
    chk("rsvd_err", 64'(last_err), 64'd1);
    chk("rsvd_latency", 64'(done_cyc - rise1), 64'd1);
    chk("rsvd_noload", 64'(nload), 64'(nl));

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ioports_host_sequencer.md
Name: ioports_host_sequencer

Overview:
- Arbitrates two 32-bit port-access requesters (e.g. coefficient loader and control FSM) onto the single byte-serial command bus of the general-purpose I/O port block.
- Serialises WRITE, READ and RESET-PORTS transactions into that block's load/datain command protocol and its ready/enout/dataout read handshake.
- Returns read data and status per requester.
- Sits between on-chip masters and the I/O port block, in place of the external host link.

Parameters:
- LOAD_GAP, 1: idle cycles (load=0) inserted between consecutive load pulses; 0 = back-to-back.
- F_HOLD, 2: extra idle cycles after any write to port 15, covering the auto-return-to-zero delay, during which the port block ignores load.
- TIMEOUT, 255: maximum cycles waited for an enout edge before aborting a read; 8-bit counter.

Ports:
- clk, in, 1: master clock.
- reset, in, 1: synchronous, active-low reset.
- req0_valid, in, 1: requester 0 transaction request; held with its fields until done0.
- req0_op, in, 2: 00 write, 01 read, 10 reset-ports, 11 reserved.
- req0_addr, in, 4: port address.
- req0_wdata, in, 32: write data.
- req1_valid, req1_op, req1_addr, req1_wdata, in, 1/2/4/32: same for requester 1.
- done0, done1, out, 1: one-cycle completion pulse to the owning requester.
- rsp_err, out, 1: valid with done pulse; 1 = timeout or reserved op.
- rsp_rdata, out, 32: valid with done pulse for reads.
- busy, out, 1: transaction in progress.
- io_load, out, 1: byte strobe to port block.
- io_datain, out, 8: command/data byte.
- io_ready, out, 1: ready to consume read byte.
- io_enout, in, 1: read byte valid.
- io_dataout, in, 8: read byte.

Behaviour:
- Reset (reset=0 at a clk edge): all outputs 0, FSM in IDLE, round-robin pointer set so requester 0 wins first.
- Reset mid-transaction aborts it with no done pulse. The port block shares the same reset.
- States:
  - IDLE
  - CMD
  - GAP
  - WBYTE
  - RREQ
  - RREL
  - HOLD
  - FIN
- IDLE:
  - If any valid, grant (round-robin when both valid: the requester not granted last wins).
  - Latch op/addr/wdata and owner into registers; busy=1 from next cycle; go to CMD.
  - Reserved op: go straight to FIN with err=1 and no bus activity.
- CMD:
  - io_load=1 for one cycle.
  - io_datain = {1'b0, cmd[2:0], addr}: cmd is 010 write, 011 read, 001 reset-ports.
  - Reset-ports then goes to FIN.
- Write:
  - After CMD, four data bytes, MS byte first, each a single-cycle load.
  - Every two load pulses are separated by exactly LOAD_GAP cycles in GAP.
  - io_datain holds the byte only while io_load=1; it is 0 otherwise.
- Write latency with LOAD_GAP=1: grant at cycle T0, loads at T1, T3, T5, T7, T9, done at T10.
- Write to addr 15: after the last byte, HOLD for F_HOLD+1 cycles before FIN.
- Read:
  - After CMD plus LOAD_GAP idle cycles, for each of 4 bytes: RREQ drives io_ready=1 until io_enout=1.
  - In that cycle capture io_dataout into rdata[31:24], then [23:16], [15:8], [7:0] in order.
  - Go to RREL with io_ready=0 and wait for io_enout=0.
- Enout timeout:
  - The counter resets on entry to RREQ/RREL; it expires when TIMEOUT cycles elapse without the awaited edge.
  - On expiry: ready=0, err=1, rsp_rdata=0, go to FIN.
- FIN:
  - Pulse done of the owner for one cycle, with rsp_err/rsp_rdata valid; rsp_rdata=0 for non-reads.
  - Return to IDLE; new arbitration takes at least 1 cycle after done.
- A requester deasserting valid mid-transaction has no effect; the transaction completes.
- io_enout arriving while not in RREQ/RREL is ignored.
- No two transactions overlap.

Decomposition:
- Shared package holds:
  - op encodings (OP_WRITE, OP_READ, OP_RSTP).
  - port-block command codes (CMD_RESET=3'b001, CMD_WRITE=3'b010, CMD_READ=3'b011).
  - state encoding.
  - ADDR_AUTOZERO=4'hF.
- One natural sub-module: ioports_rr_arb2, a 2-way round-robin arbiter with a grant pointer updated on accept.

Test Plan:
- Write port 3: req0 op=00, addr=3, wdata=32'h12345678, LOAD_GAP=1 -> loads at T1..T9 with bytes 8'h23, 12, 34, 56, 78; port block out3=32'h12345678; done0 at T10, err=0.
- Read port 2: in2=32'hCAFEF00D, req1 op=01 addr=2 -> 4 ready/enout handshakes; done1 with rsp_rdata=32'hCAFEF00D, err=0; ready low whenever enout high is seen low again.
- Arbitration: req0 and req1 both writing, valid in the same cycle, repeated 3 times -> grants alternate 0,1,0,1,0,1; never two consecutive grants to one requester while the other waits.
- Port 15: write 32'h1 to addr F, then immediately another write from req1 to addr F -> second command byte issued no earlier than F_HOLD+1 cycles after the last byte; outf returns to 0 and the second write lands.
- Timeout: read with io_enout tied 0, TIMEOUT=8 -> done pulse 8 cycles after ready rise with err=1, rdata=0, ready=0; next request is served normally.
- Reset mid-read after 2 bytes -> next cycle all outputs 0, no done pulse; a subsequent read of in0=32'hA5A5A5A5 returns the correct value.
- Reserved op 11 -> done on the cycle after grant, err=1, no io_load pulse.
